x_line_buffer: RTL and testbench

Parametrised line buffer feeding the convolution ALU with a KROWS-tall column of input pixels per cycle. Holds KROWS+1 zero-padded row slots in a ring: one slot is filled from the 32-bit load stream while the other KROWS rotate pixel-by-pixel under ALU control. It replaces the fixed 28-pixel, 3-row buffer with generic row width, kernel height, padding and a ready/valid load handshake, and it generates bottom padding rows internally. It sits between the input fetch unit and the MAC array.

---
 rtl/x_buf_pkg.sv | 21 ++
 rtl/x_row_slot.sv | 63 ++++++
 rtl/x_line_buffer.sv | 183 ++++++++++++++++++
 tb/tb_x_line_buffer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/x_buf_pkg.sv
// Shared types and size helpers for the x_line_buffer slice.
package x_buf_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      FULL = 2'd2,
      ZERO = 2'd3
   } state_t;

   // Pixels held per row slot: valid pixels plus zero padding on both ends.
   function automatic int unsigned slot_len(input int unsigned row_pix, input int unsigned pad);
      return row_pix + 2 * pad;
   endfunction

   // Load words needed to fill the valid part of one row.
   function automatic int unsigned words_per_row(input int unsigned row_pix, input int unsigned word_pix);
      return row_pix / word_pix;
   endfunction

endpackage

// File: rtl/x_row_slot.sv
// One zero-padded row slot: clear, word write, rotate by 1 and by 2*PAD pixels.
module x_row_slot
   import x_buf_pkg::*;
#(
   parameter int unsigned PIX_W    = 8,
   parameter int unsigned ROW_PIX  = 28,
   parameter int unsigned PAD      = 1,
   parameter int unsigned WORD_PIX = 4,
   parameter int unsigned IDX_W    = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr,
   input  logic                      wr_en,
   input  logic [IDX_W-1:0]          wr_idx,
   input  logic [WORD_PIX*PIX_W-1:0] wr_data,
   input  logic                      rot1,
   input  logic                      rot_pad,
   output logic [PIX_W-1:0]          px0
);

   localparam int unsigned L      = slot_len(ROW_PIX, PAD);
   localparam int unsigned WPR    = words_per_row(ROW_PIX, WORD_PIX);
   localparam int unsigned SLOT_W = L * PIX_W;
   localparam int unsigned WORD_W = WORD_PIX * PIX_W;

   logic [SLOT_W-1:0] data;
   logic [SLOT_W-1:0] rot1_val;
   logic [SLOT_W-1:0] rot_pad_val;

   // Rotation toward pixel 0: pixel 0 wraps to the far end of the slot.
   assign rot1_val = {data[PIX_W-1:0], data[SLOT_W-1:PIX_W]};

   generate
      if (PAD > 0) begin : g_pad
         assign rot_pad_val = {data[2*PAD*PIX_W-1:0], data[SLOT_W-1:2*PAD*PIX_W]};
      end else begin : g_nopad
         assign rot_pad_val = data;
      end
   endgenerate

   // Slot storage; clear wins over write, write over rotations.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data <= '0;
      end else if (clr) begin
         data <= '0;
      end else if (wr_en) begin
         for (int unsigned k = 0; k < WPR; k++) begin
            if (wr_idx == IDX_W'(k)) begin
               data[(PAD + k * WORD_PIX) * PIX_W +: WORD_W] <= wr_data;
            end
         end
      end else if (rot_pad) begin
         data <= rot_pad_val;
      end else if (rot1) begin
         data <= rot1_val;
      end
   end

   assign px0 = data[PIX_W-1:0];

endmodule

// File: rtl/x_line_buffer.sv
// Ring of KROWS+1 row slots: one slot loads from the word stream while KROWS
// rotate under ALU control. Optional underrun flag: X_LINE_BUFFER_UNDERRUN_CHECK_EN.
module x_line_buffer
   import x_buf_pkg::*;
#(
   parameter int unsigned PIX_W    = 8,
   parameter int unsigned ROW_PIX  = 28,
   parameter int unsigned PAD      = 1,
   parameter int unsigned WORD_PIX = 4,
   parameter int unsigned KROWS    = 3,
   parameter int unsigned ROWS     = 28
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   input  logic                               load_valid,
   input  logic [WORD_PIX*PIX_W-1:0]          load_data,
   output logic                               load_ready,
   input  logic                               shift_en,
   input  logic                               row_advance,
   output logic [KROWS*PIX_W-1:0]             win_data,
   output logic                               load_done,
   output logic [$clog2(ROWS+PAD+1)-1:0]      row_idx,
   output logic                               err
);

   localparam int unsigned NSLOT = KROWS + 1;
   localparam int unsigned B_W   = $clog2(NSLOT);
   localparam int unsigned WPR   = words_per_row(ROW_PIX, WORD_PIX);
   localparam int unsigned WC_W  = $clog2(WPR + 1);
   localparam int unsigned RL_W  = $clog2(ROWS + 1);
   localparam int unsigned RI_W  = $clog2(ROWS + PAD + 1);

   state_t            state;
   state_t            state_n;
   logic [B_W-1:0]    b;
   logic [B_W-1:0]    b_inc;
   logic [WC_W-1:0]   wcnt;
   logic [RL_W-1:0]   rows_loaded;
   logic [RI_W-1:0]   row_idx_q;
   logic              load_done_q;
   logic              load_done_n;
   logic              xfer;
   logic              last_word;
   logic [B_W:0]      sum;
   logic [PIX_W-1:0]  px0 [NSLOT];

   assign load_ready = (state == FILL);
   assign xfer       = (state == FILL) && load_valid && !start && !row_advance;
   assign last_word  = xfer && (wcnt == WC_W'(WPR - 1));
   assign b_inc      = (b == B_W'(NSLOT - 1)) ? '0 : b + B_W'(1);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next state and load-complete pulse request.
   always_comb begin
      state_n     = state;
      load_done_n = 1'b0;
      if (start) begin
         state_n = FILL;
      end else if (row_advance) begin
         case (state)
            FILL:    state_n = FILL;
            FULL:    state_n = (rows_loaded < RL_W'(ROWS)) ? FILL : ZERO;
            ZERO:    state_n = ZERO;
            default: state_n = state;
         endcase
         load_done_n = (state_n == ZERO);
      end else if (last_word) begin
         state_n     = FULL;
         load_done_n = 1'b1;
      end
   end

   // Ring base, word/row counters and the registered load_done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         b           <= '0;
         wcnt        <= '0;
         rows_loaded <= '0;
         row_idx_q   <= '0;
         load_done_q <= 1'b0;
      end else begin
         load_done_q <= load_done_n;
         if (start) begin
            b           <= '0;
            wcnt        <= '0;
            rows_loaded <= '0;
            row_idx_q   <= '0;
         end else if (row_advance) begin
            b    <= b_inc;
            wcnt <= '0;
            if (row_idx_q != RI_W'(ROWS + PAD)) row_idx_q <= row_idx_q + RI_W'(1);
         end else if (xfer) begin
            wcnt <= wcnt + WC_W'(1);
            if (last_word && rows_loaded != RL_W'(ROWS)) rows_loaded <= rows_loaded + RL_W'(1);
         end
      end
   end

   assign row_idx   = row_idx_q;
   assign load_done = load_done_q;

   // Slot b loads; every other slot is an active row and rotates.
   genvar s;
   generate
      for (s = 0; s < NSLOT; s++) begin : g_slot
         logic is_load;
         logic s_clr;
         logic s_wr;
         logic s_rot1;
         logic s_rot_pad;

         assign is_load   = (b == B_W'(s));
         assign s_clr     = start || (row_advance && b_inc == B_W'(s));
         assign s_wr      = xfer && is_load;
         assign s_rot_pad = row_advance && !start && !is_load;
         assign s_rot1    = shift_en && !start && !row_advance && !is_load;

         x_row_slot #(
            .PIX_W    (PIX_W),
            .ROW_PIX  (ROW_PIX),
            .PAD      (PAD),
            .WORD_PIX (WORD_PIX),
            .IDX_W    (WC_W)
         ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .clr     (s_clr),
            .wr_en   (s_wr),
            .wr_idx  (wcnt),
            .wr_data (load_data),
            .rot1    (s_rot1),
            .rot_pad (s_rot_pad),
            .px0     (px0[s])
         );
      end
   endgenerate

   // Window mux: active row j lives in slot (b+1+j) mod NSLOT.
   always_comb begin
      win_data = '0;
      sum      = '0;
      for (int unsigned j = 0; j < KROWS; j++) begin
         sum = {1'b0, b} + (B_W+1)'(j + 1);
         if (sum >= (B_W+1)'(NSLOT)) sum = sum - (B_W+1)'(NSLOT);
         win_data[j*PIX_W +: PIX_W] = px0[sum[B_W-1:0]];
      end
   end

`ifdef X_LINE_BUFFER_UNDERRUN_CHECK_EN
   localparam int unsigned L    = slot_len(ROW_PIX, PAD);
   localparam int unsigned SC_W = $clog2(L + 1);

   logic [SC_W-1:0] scnt;
   logic            err_q;

   // Sticky underrun: incomplete load or wrong shift count at row_advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scnt  <= '0;
         err_q <= 1'b0;
      end else if (start) begin
         scnt  <= '0;
         err_q <= 1'b0;
      end else if (row_advance) begin
         scnt <= '0;
         if (state == FILL || scnt != SC_W'(ROW_PIX)) err_q <= 1'b1;
      end else if (shift_en && scnt != SC_W'(L)) begin
         scnt <= scnt + SC_W'(1);
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_x_line_buffer.sv
// Directed self-checking bench for x_line_buffer (default parameters).
module tb_x_line_buffer;

   localparam int unsigned PIX_W    = 8;
   localparam int unsigned ROW_PIX  = 28;
   localparam int unsigned PAD      = 1;
   localparam int unsigned WORD_PIX = 4;
   localparam int unsigned KROWS    = 3;
   localparam int unsigned ROWS     = 28;
   localparam int unsigned RI_W     = $clog2(ROWS + PAD + 1);

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      start;
   logic                      load_valid;
   logic [WORD_PIX*PIX_W-1:0] load_data;
   logic                      load_ready;
   logic                      shift_en;
   logic                      row_advance;
   logic [KROWS*PIX_W-1:0]    win_data;
   logic                      load_done;
   logic [RI_W-1:0]           row_idx;
   logic                      err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   x_line_buffer #(
      .PIX_W(PIX_W), .ROW_PIX(ROW_PIX), .PAD(PAD),
      .WORD_PIX(WORD_PIX), .KROWS(KROWS), .ROWS(ROWS)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
      .shift_en(shift_en), .row_advance(row_advance), .win_data(win_data),
      .load_done(load_done), .row_idx(row_idx), .err(err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Word k of a row: pixels 4k+1..4k+4 plus a per-row offset, pixel 0 in LSBs.
   function automatic logic [31:0] word_of(input int unsigned k, input logic [7:0] off);
      logic [31:0] w;
      for (int i = 0; i < 4; i++) w[i*8 +: 8] = 8'(4 * k + i + 1) + off;
      return w;
   endfunction

   task automatic send_word(input int unsigned k, input logic [7:0] off);
      load_valid = 1'b1;
      load_data  = word_of(k, off);
      tick();
      load_valid = 1'b0;
   endtask

   task automatic load_row(input logic [7:0] off);
      for (int unsigned k = 0; k < 7; k++) send_word(k, off);
   endtask

   task automatic shift_n(input int n);
      shift_en = 1'b1;
      repeat (n) tick();
      shift_en = 1'b0;
   endtask

   task automatic advance();
      row_advance = 1'b1;
      tick();
      row_advance = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; load_valid = 1'b0; load_data = '0;
      shift_en = 1'b0; row_advance = 1'b0;
      tick(); tick();
      checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL reset_load_ready got %b want 0", load_ready); end
      checks++; if (win_data !== 24'h0) begin errors++; $display("FAIL reset_win got %h want 000000", win_data); end
      checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done got %b want 0", load_done); end
      checks++; if (row_idx !== 5'd0) begin errors++; $display("FAIL reset_row_idx got %0d want 0", row_idx); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
      rst = 1'b0;
      tick();
      checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL idle_load_ready got %b want 0", load_ready); end
   endtask

   task automatic test_load_row();
      logic [7:0] px;
      do_start();
      checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL fill_ready got %b want 1", load_ready); end
      for (int unsigned k = 0; k < 7; k++) begin
         send_word(k, 8'h00);
         if (k < 6) begin
            checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL early_done word %0d got %b want 0", k, load_done); end
            checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL mid_ready word %0d got %b want 1", k, load_ready); end
         end
      end
      checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL done_pulse got %b want 1", load_done); end
      checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", load_ready); end
      tick();
      checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL done_once got %b want 0", load_done); end
      advance();
      checks++; if (row_idx !== 5'd1) begin errors++; $display("FAIL adv_row_idx got %0d want 1", row_idx); end
      checks++; if (win_data !== 24'h0) begin errors++; $display("FAIL slot_px0 got %h want 000000", win_data); end
      for (int m = 1; m <= 29; m++) begin
         shift_n(1);
         px = (m <= 28) ? 8'(m) : 8'h00;
         checks++; if (win_data !== {px, 16'h0000}) begin errors++; $display("FAIL slot_px%0d got %h want %h", m, win_data, {px, 16'h0000}); end
      end
   endtask

   task automatic test_window();
      do_start();
      for (int r = 0; r < 3; r++) begin
         load_row(8'(r * 32));
         shift_n(28);
         advance();
      end
      checks++; if (row_idx !== 5'd3) begin errors++; $display("FAIL win_row_idx got %0d want 3", row_idx); end
      checks++; if (win_data !== 24'h000000) begin errors++; $display("FAIL win_pad got %h want 000000", win_data); end
      shift_n(1);
      checks++; if (win_data !== 24'h412101) begin errors++; $display("FAIL win_px1 got %h want 412101", win_data); end
      shift_n(27);
      checks++; if (win_data !== 24'h5C3C1C) begin errors++; $display("FAIL win_px28 got %h want 5c3c1c", win_data); end
      advance();
      checks++; if (win_data !== 24'h000000) begin errors++; $display("FAIL wrap_px0 got %h want 000000", win_data); end
      checks++; if (row_idx !== 5'd4) begin errors++; $display("FAIL wrap_row_idx got %0d want 4", row_idx); end
      shift_n(1);
      checks++; if (win_data !== 24'h004121) begin errors++; $display("FAIL wrap_px1 got %h want 004121", win_data); end
   endtask

   task automatic test_zero_rows();
      do_start();
      for (int r = 0; r < 28; r++) begin
         load_row(8'(r));
         shift_n(28);
         if (r == 27) begin
            checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL last_full_ready got %b want 0", load_ready); end
         end
         advance();
      end
      checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", load_done); end
      checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL zero_ready got %b want 0", load_ready); end
      checks++; if (row_idx !== 5'd28) begin errors++; $display("FAIL zero_row_idx got %0d want 28", row_idx); end
      // Stray words while in ZERO must be ignored.
      load_valid = 1'b1;
      load_data  = 32'hFFFF_FFFF;
      tick();
      checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL zero_done_once got %b want 0", load_done); end
      tick();
      load_valid = 1'b0;
      shift_n(28);
      advance();
      checks++; if (row_idx !== 5'd29) begin errors++; $display("FAIL bottom_row_idx got %0d want 29", row_idx); end
      checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL bottom_done got %b want 1", load_done); end
      checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL bottom_ready got %b want 0", load_ready); end
      for (int m = 1; m <= 3; m++) begin
         shift_n(1);
         checks++;
         if (win_data !== {8'h00, 8'(m + 27), 8'(m + 26)}) begin
            errors++; $display("FAIL bottom_px%0d got %h want %h", m, win_data, {8'h00, 8'(m + 27), 8'(m + 26)});
         end
      end
      advance();
      checks++; if (row_idx !== 5'd29) begin errors++; $display("FAIL row_idx_sat got %0d want 29", row_idx); end
   endtask

   task automatic test_underrun();
      do_start();
      for (int unsigned k = 0; k < 3; k++) send_word(k, 8'h00);
      advance();
      checks++; if (row_idx !== 5'd1) begin errors++; $display("FAIL partial_row_idx got %0d want 1", row_idx); end
      checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL partial_ready got %b want 1", load_ready); end
      shift_n(1);
      checks++; if (win_data !== 24'h010000) begin errors++; $display("FAIL partial_px1 got %h want 010000", win_data); end
      shift_n(11);
      checks++; if (win_data !== 24'h0C0000) begin errors++; $display("FAIL partial_px12 got %h want 0c0000", win_data); end
      shift_n(1);
      checks++; if (win_data !== 24'h000000) begin errors++; $display("FAIL partial_px13 got %h want 000000", win_data); end
`ifdef X_LINE_BUFFER_UNDERRUN_CHECK_EN
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL underrun_err got %b want 1", err); end
      tick();
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL underrun_sticky got %b want 1", err); end
      do_start();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL underrun_clear got %b want 0", err); end
`else
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_tied got %b want 0", err); end
`endif
   endtask

   task automatic test_start_advance();
      do_start();
      load_row(8'h10);
      shift_n(28);
      advance();
      send_word(0, 8'h40);
      send_word(1, 8'h40);
      start = 1'b1; row_advance = 1'b1; shift_en = 1'b1;
      load_valid = 1'b1; load_data = 32'hA5A5_A5A5;
      tick();
      start = 1'b0; row_advance = 1'b0; shift_en = 1'b0; load_valid = 1'b0;
      checks++; if (row_idx !== 5'd0) begin errors++; $display("FAIL sa_row_idx got %0d want 0", row_idx); end
      checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL sa_ready got %b want 1", load_ready); end
      checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL sa_done got %b want 0", load_done); end
      checks++; if (win_data !== 24'h000000) begin errors++; $display("FAIL sa_px0 got %h want 000000", win_data); end
      shift_n(1);
      checks++; if (win_data !== 24'h000000) begin errors++; $display("FAIL sa_px1 got %h want 000000", win_data); end
      shift_n(3);
      checks++; if (win_data !== 24'h000000) begin errors++; $display("FAIL sa_px4 got %h want 000000", win_data); end
`ifndef X_LINE_BUFFER_UNDERRUN_CHECK_EN
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL sa_err got %b want 0", err); end
`endif
   endtask

   initial begin
      test_reset();
      test_load_row();
      test_window();
      test_zero_rows();
      test_underrun();
      test_start_advance();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
